// File: rtl/fifo_rd_ptr_ctrl.sv
// Read-side pointer controller for an asynchronous FIFO. It owns the read pointer,
// the RAM read address, the empty/almost-empty flags and underflow detection.
module fifo_rd_ptr_ctrl #(
    parameter int ADDR_WIDTH          = 4,
    parameter int ALMOST_EMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH:0]   wr_ptr_gray_sync,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH:0]   rd_ptr_gray,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  rd_valid,
    output logic                  underflow
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] THRESH = PW'(ALMOST_EMPTY_THRESH);

    // Handshake: a read is taken on any edge where rd_en=1 and the registered
    // empty=0; rd_valid pulses for exactly one cycle after each taken read.

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] rd_bin;
    logic [PW-1:0] rd_bin_next;
    logic [PW-1:0] rd_gray_next;
    logic [PW-1:0] wr_bin;
    logic [PW-1:0] level;
    logic          rd_acc;

    always_comb begin
        rd_acc       = rd_en & ~empty;
        rd_bin_next  = rd_bin + {{ADDR_WIDTH{1'b0}}, rd_acc};
        rd_gray_next = bin2gray(rd_bin_next);
        wr_bin       = gray2bin(wr_ptr_gray_sync);
        // Pointers carry one extra wrap bit, so a full FIFO gives 2**ADDR_WIDTH, not 0.
        level        = wr_bin - rd_bin_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_bin       <= '0;
            rd_ptr_gray  <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rd_valid     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            rd_bin       <= rd_bin_next;
            rd_ptr_gray  <= rd_gray_next;
            // Compare against the post-read pointer so the last read sets empty on the same edge.
            empty        <= (rd_gray_next == wr_ptr_gray_sync);
            almost_empty <= (level <= THRESH);
            rd_valid     <= rd_acc;
            underflow    <= rd_en & empty;
        end
    end

    assign rd_addr = rd_bin[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_fifo_rd_ptr_ctrl.sv
// Bench for fifo_rd_ptr_ctrl: occupancy model built from integer write/read counts,
// plus a small RAM and data scoreboard that checks FIFO ordering through rd_addr.
module tb_fifo_rd_ptr_ctrl;

    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rd_en = 1'b0;
    logic [AW:0]   wr_ptr_gray_sync = '0;
    logic [AW-1:0] rd_addr;
    logic [AW:0]   rd_ptr_gray;
    logic          empty;
    logic          almost_empty;
    logic          rd_valid;
    logic          underflow;

    fifo_rd_ptr_ctrl #(.ADDR_WIDTH(AW), .ALMOST_EMPTY_THRESH(2)) dut (
        .clk(clk),
        .rst(rst),
        .rd_en(rd_en),
        .wr_ptr_gray_sync(wr_ptr_gray_sync),
        .rd_addr(rd_addr),
        .rd_ptr_gray(rd_ptr_gray),
        .empty(empty),
        .almost_empty(almost_empty),
        .rd_valid(rd_valid),
        .underflow(underflow)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // RAM with one-cycle registered read, data scoreboard
    logic [7:0] mem [DEPTH];
    logic [7:0] ram_dout;
    logic [7:0] exp_q[$];

    always @(posedge clk) ram_dout <= mem[rd_addr];

    // reference model: plain counts of entries written and read
    int   checks = 0;
    int   failures = 0;
    int   m_wr = 0;
    int   m_rd = 0;
    logic e_empty = 1'b1;
    logic e_almost = 1'b1;
    logic e_valid = 1'b0;
    logic e_under = 1'b0;

    function automatic logic [AW:0] to_gray(input int cnt);
        logic [AW:0] b;
        b = (AW+1)'(cnt % (2 * DEPTH));
        return b ^ (b >> 1);
    endfunction

    function automatic logic [12:0] got();
        return {rd_addr, rd_ptr_gray, empty, almost_empty, rd_valid, underflow};
    endfunction

    function automatic logic [12:0] want();
        logic [AW-1:0] a;
        a = AW'(m_rd % DEPTH);
        return {a, to_gray(m_rd), e_empty, e_almost, e_valid, e_under};
    endfunction

    // driver: push nwr new entries, present inputs for one edge, advance the model
    task automatic drive_cycle(input logic r, input int nwr, input logic rs);
        logic [7:0] d;
        logic       acc;
        int         lvl;
        for (int i = 0; i < nwr; i++) begin
            d = 8'($urandom);
            mem[m_wr % DEPTH] = d;
            exp_q.push_back(d);
            m_wr++;
        end
        rd_en = r;
        rst = rs;
        wr_ptr_gray_sync = to_gray(m_wr);
        @(posedge clk);
        if (rs) begin
            m_rd = 0;
            e_empty = 1'b1;
            e_almost = 1'b1;
            e_valid = 1'b0;
            e_under = 1'b0;
            exp_q.delete();
        end else begin
            acc = r && !e_empty;
            e_under = r && e_empty;
            if (acc) m_rd++;
            lvl = m_wr - m_rd;
            e_empty = (lvl == 0);
            e_almost = (lvl <= 2);
            e_valid = acc;
        end
        #1;
        if (rd_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_data: rd_valid with no expected entry, got data=%h", ram_dout);
            end else begin
                d = exp_q.pop_front();
                if (ram_dout !== d) begin
                    failures++;
                    $display("FAIL sb_data: got %h expected %h", ram_dout, d);
                end
            end
        end
    endtask

    task automatic do_reset();
        m_wr = 0;
        drive_cycle(1'b0, 0, 1'b1);
    endtask

    task automatic test_reset();
        m_wr = 2;
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b1, 0, 1'b1);
            checks++;
            if (got() !== 13'b0000_00000_1100) begin
                failures++;
                $display("FAIL reset: got %b expected %b", got(), 13'b0000_00000_1100);
            end
        end
        m_wr = 0;
        drive_cycle(1'b0, 0, 1'b0);
        checks++;
        if (got() !== want()) begin failures++; $display("FAIL reset_release: got %b expected %b", got(), want()); end
    endtask

    task automatic test_single();
        do_reset();
        drive_cycle(1'b0, 1, 1'b0);
        checks++;
        if (empty !== 1'b0 || got() !== want()) begin
            failures++; $display("FAIL single_write: got %b expected %b", got(), want());
        end
        drive_cycle(1'b1, 0, 1'b0);
        checks++;
        if (rd_addr !== 4'd1 || rd_ptr_gray !== 5'b00001 || empty !== 1'b1 || got() !== want()) begin
            failures++; $display("FAIL single_read: got %b expected %b", got(), want());
        end
        drive_cycle(1'b0, 0, 1'b0);
        checks++;
        if (rd_valid !== 1'b0 || got() !== want()) begin
            failures++; $display("FAIL single_valid_pulse: got %b expected %b", got(), want());
        end
    endtask

    task automatic test_underflow();
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 0, 1'b0);
            checks++;
            if (underflow !== 1'b1 || rd_valid !== 1'b0 || got() !== want()) begin
                failures++; $display("FAIL underflow_%0d: got %b expected %b", i, got(), want());
            end
        end
        drive_cycle(1'b0, 0, 1'b0);
        checks++;
        if (underflow !== 1'b0 || got() !== want()) begin
            failures++; $display("FAIL underflow_clear: got %b expected %b", got(), want());
        end
    endtask

    task automatic test_almost_empty();
        do_reset();
        drive_cycle(1'b0, 3, 1'b0);
        checks++;
        if (almost_empty !== 1'b0 || got() !== want()) begin
            failures++; $display("FAIL almost_level3: got %b expected %b", got(), want());
        end
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 0, 1'b0);
            checks++;
            if (almost_empty !== 1'b1 || got() !== want()) begin
                failures++; $display("FAIL almost_read_%0d: got %b expected %b", i, got(), want());
            end
        end
        checks++;
        if (empty !== 1'b1) begin failures++; $display("FAIL almost_drained: got empty=%b expected 1", empty); end
    endtask

    task automatic test_wrap_full();
        do_reset();
        drive_cycle(1'b0, DEPTH, 1'b0);
        checks++;
        if (empty !== 1'b0 || almost_empty !== 1'b0 || got() !== want()) begin
            failures++; $display("FAIL full_level: got %b expected %b", got(), want());
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive_cycle(1'b1, 0, 1'b0);
            checks++;
            if (rd_valid !== 1'b1 || got() !== want()) begin
                failures++; $display("FAIL wrap_read_%0d: got %b expected %b", i, got(), want());
            end
        end
        checks++;
        if (rd_addr !== 4'd0 || rd_ptr_gray !== 5'b11000 || empty !== 1'b1) begin
            failures++; $display("FAIL wrap_end: got addr=%0d gray=%b empty=%b expected 0 11000 1",
                                 rd_addr, rd_ptr_gray, empty);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        drive_cycle(1'b0, 1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, 1, 1'b0);
            checks++;
            if (empty !== 1'b0 || almost_empty !== 1'b1 || got() !== want()) begin
                failures++; $display("FAIL simul_rw_%0d: got %b expected %b", i, got(), want());
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        drive_cycle(1'b0, 8, 1'b0);
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 0, 1'b0);
        checks++;
        if (got() !== want()) begin failures++; $display("FAIL burst_pre_reset: got %b expected %b", got(), want()); end
        drive_cycle(1'b1, 0, 1'b1);
        checks++;
        if (got() !== 13'b0000_00000_1100) begin
            failures++; $display("FAIL mid_reset: got %b expected %b", got(), 13'b0000_00000_1100);
        end
        m_wr = 0;
        drive_cycle(1'b0, 0, 1'b0);
        checks++;
        if (rd_valid !== 1'b0 || underflow !== 1'b0 || got() !== want()) begin
            failures++; $display("FAIL post_reset: got %b expected %b", got(), want());
        end
    endtask

    task automatic test_random();
        int nwr;
        int room;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            room = DEPTH - (m_wr - m_rd);
            if ($urandom_range(0, 19) == 0) nwr = $urandom_range(0, room);
            else nwr = (room < 2) ? $urandom_range(0, room) : $urandom_range(0, 2);
            if ($urandom_range(0, 149) == 0) begin
                drive_cycle(1'(($urandom_range(0, 1))), nwr, 1'b1);
                m_wr = 0;
            end else begin
                drive_cycle(1'($urandom_range(0, 1)), nwr, 1'b0);
            end
            checks++;
            if (got() !== want()) begin
                failures++; $display("FAIL random_%0d: got %b expected %b", i, got(), want());
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_underflow();
        test_almost_empty();
        test_wrap_full();
        test_simultaneous();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_rd_ptr_ctrl.md
Name: fifo_rd_ptr_ctrl

Overview:
Read-side pointer controller for the asynchronous FIFO. It lives in the read clock domain and consumes the write pointer after the two-flop Gray synchronizer. It owns the read pointer, RAM read address, empty/almost-empty flags and underflow detection. It exports its own Gray read pointer, which the write domain synchronizes.

Parameters:
ADDR_WIDTH, 4, RAM address width; FIFO depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
ALMOST_EMPTY_THRESH, 2, almost_empty asserts when fill level <= this value; legal range 0..2**ADDR_WIDTH.

Ports:
clk  input  1  read-domain clock
rst  input  1  synchronous, active-high reset
rd_en  input  1  read request from consumer
wr_ptr_gray_sync  input  ADDR_WIDTH+1  write pointer, Gray coded, already synchronized to clk
rd_addr  output  ADDR_WIDTH  RAM read address; equals rd_bin[ADDR_WIDTH-1:0]
rd_ptr_gray  output  ADDR_WIDTH+1  registered Gray read pointer, to the write-domain synchronizer
empty  output  1  FIFO empty, registered
almost_empty  output  1  fill level <= ALMOST_EMPTY_THRESH, registered
rd_valid  output  1  RAM data valid; one-cycle pulse, one cycle after an accepted read
underflow  output  1  one-cycle pulse when rd_en is high while empty is high

Behaviour:
- Single clock domain. All outputs are driven from flops; no combinational input-to-output path.
- Reset is synchronous, active-high and overrides all other activity. On a clk edge with rst=1:
  - rd_bin=0, rd_ptr_gray=0, rd_addr=0
  - empty=1, almost_empty=1
  - rd_valid=0, underflow=0
- Read acceptance: rd_acc = rd_en & ~empty, using the registered empty.
- Pointer update:
  - rd_bin_next = rd_bin + rd_acc, modulo 2**(ADDR_WIDTH+1). The natural wrap toggles the MSB.
  - rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1).
  - On each edge, rd_bin <= rd_bin_next and rd_ptr_gray <= rd_gray_next.
- Empty:
  - empty <= (rd_gray_next == wr_ptr_gray_sync), a full-width compare including the MSB.
  - Empty deasserts one cycle after the synchronized pointer moves.
  - Empty asserts in the same edge that consumes the last entry; there is no extra bubble.
- Fill level:
  - wr_bin = Gray-to-binary conversion of wr_ptr_gray_sync (XOR prefix from the MSB).
  - level = (wr_bin - rd_bin_next) mod 2**(ADDR_WIDTH+1).
  - almost_empty <= (level <= ALMOST_EMPTY_THRESH).
  - level ranges 0..2**ADDR_WIDTH. A value of exactly 2**ADDR_WIDTH (full) is legal and must not alias to 0.
- rd_valid <= rd_acc. The RAM has one-cycle registered read latency: data at address rd_addr, sampled at the accepting edge, is valid while rd_valid=1.
- underflow <= rd_en & empty. The pointer does not move on an underflow.
- Simultaneous events:
  - A read accepted in the same cycle the write pointer advances: level is computed from both new values.
  - empty is recomputed from rd_gray_next, so a read of the last entry coinciding with a new write leaves empty=0.
- Pessimism: the synchronized write pointer lags, so empty may be held longer than strictly necessary. It must never deassert early. The controller trusts wr_ptr_gray_sync: it does no Gray-validity checking, and changes of more than one bit between cycles are treated as given.
- Reset mid-operation: all state returns to reset values on the next edge. A read requested in the reset cycle is dropped, with no rd_valid and no underflow.
- Implementation is flat RTL: pointer register, Gray encoder/decoder functions, subtractor and comparators. No instantiated RAM.

Test Plan:
- Reset: hold rst=1 for 2 cycles with rd_en=1 and wr_ptr_gray_sync=5'b00011 -> rd_addr=0, rd_ptr_gray=0, empty=1, almost_empty=1, rd_valid=0, underflow=0 throughout.
- Single entry: wr_ptr_gray_sync 0->5'b00001 -> empty=0 next edge.
  - Then rd_en for 1 cycle -> rd_addr 0->1, rd_ptr_gray=5'b00001, empty=1 at the same edge, rd_valid=1 for exactly one cycle after.
- Underflow: empty=1, rd_en=1 for 3 cycles -> underflow high for 3 cycles (one cycle delayed), rd_addr and rd_ptr_gray unchanged, rd_valid=0.
- Almost-empty (THRESH=2):
  - wr_ptr_gray_sync=5'b00010 (bin 3) -> almost_empty=0.
  - One read -> level 2 -> almost_empty=1; two more reads -> empty=1.
- Wrap and full level:
  - wr_ptr_gray_sync=5'b11000 (bin 16) from reset -> empty=0, almost_empty=0 (level 16, not 0).
  - 16 back-to-back reads -> rd_addr counts 0..15 then 0, rd_ptr_gray=5'b11000, empty=1 on the 16th accept, 16 rd_valid pulses.
- Simultaneous read/write and mid-run reset:
  - level 1, rd_en=1 while wr_ptr_gray_sync advances by 1 -> empty stays 0, level stays 1.
  - Then rst pulse during a burst -> all outputs at reset values on the next edge, no rd_valid for the dropped read.
